// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Define BIN2BCD_OVF_SAT_EN to build the overflow flag and saturate bcd to all nines on overflow.
module bin2bcd_seq #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [BCD_W-1:0] scr_reg, scr_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic [BCD_W-1:0] bcd_reg, bcd_next;
    logic             done_reg, done_next;
    logic [BCD_W-1:0] corr;

`ifdef BIN2BCD_OVF_SAT_EN
    logic acc_reg, acc_next;
    logic ovf_reg, ovf_next;
`endif

    // Add-3 correction; 10..15 cannot arise from a valid scratch and are pinned to F.
    function automatic logic [3:0] correct_digit(input logic [3:0] d);
        if (d <= 4'd4)
            return d;
        else if (d <= 4'd9)
            return d + 4'd3;
        else
            return 4'hF;
    endfunction

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_corr
            assign corr[4*gi +: 4] = correct_digit(scr_reg[4*gi +: 4]);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        scr_next   = scr_reg;
        shreg_next = shreg_reg;
        bcd_next   = bcd_reg;
        done_next  = 1'b0;
`ifdef BIN2BCD_OVF_SAT_EN
        acc_next   = acc_reg;
        ovf_next   = ovf_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    shreg_next = bin;
                    scr_next   = '0;
                    cnt_next   = CNT_W'(WIDTH);
                    state_next = SHIFT;
`ifdef BIN2BCD_OVF_SAT_EN
                    acc_next   = 1'b0;
`endif
                end
            end
            SHIFT: begin
                // The bit leaving the top digit recycles into the vacated shift-register
                // LSB; those low bits are never consumed, so the value there is don't-care.
                {scr_next, shreg_next} = {corr[BCD_W-2:0], shreg_reg, corr[BCD_W-1]};
                cnt_next = cnt_reg - CNT_W'(1);
`ifdef BIN2BCD_OVF_SAT_EN
                acc_next = acc_reg | corr[BCD_W-1];
`endif
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
`ifdef BIN2BCD_OVF_SAT_EN
                    ovf_next   = acc_next;
                    bcd_next   = acc_next ? {DIGITS{4'h9}} : scr_next;
`else
                    bcd_next   = scr_next;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            scr_reg   <= '0;
            shreg_reg <= '0;
            bcd_reg   <= '0;
            done_reg  <= 1'b0;
`ifdef BIN2BCD_OVF_SAT_EN
            acc_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            scr_reg   <= scr_next;
            shreg_reg <= shreg_next;
            bcd_reg   <= bcd_next;
            done_reg  <= done_next;
`ifdef BIN2BCD_OVF_SAT_EN
            acc_reg   <= acc_next;
            ovf_reg   <= ovf_next;
`endif
        end
    end

    assign busy = (state_reg == SHIFT);
    assign done = done_reg;
    assign bcd  = bcd_reg;
`ifdef BIN2BCD_OVF_SAT_EN
    assign overflow = ovf_reg;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and random checks of bin2bcd_seq (WIDTH=14, DIGITS=4); honours BIN2BCD_OVF_SAT_EN.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    bin2bcd_seq #(.WIDTH(14), .DIGITS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present a start for one edge; returns just after the accepting edge.
    task automatic launch(input logic [13:0] v);
        bin   = v;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts cycles to done (-1 on timeout) and busy-high samples on the way.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = -1;
        busy_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            if (busy) busy_cnt++;
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    // Decimal reference: expected {overflow, bcd} for a 4-digit result.
    function automatic logic [16:0] ref_model(input int v);
        int          m;
        logic        ovf;
        logic [15:0] r;
        ovf = (v >= 10000);
        m   = v % 10000;
        r   = '0;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(m % 10);
            m = m / 10;
        end
`ifdef BIN2BCD_OVF_SAT_EN
        if (ovf) r = 16'h9999;
        return {ovf, r};
`else
        return {1'b0, r};
`endif
    endfunction

    initial begin
        int          lat;
        int          bcnt;
        int          dn;
        int          first_n;
        logic [15:0] bcd_at;
        logic [16:0] exp_v;
        logic [13:0] rv;

        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd", 32'(bcd), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        tick();

        // Zero input: latency and busy duration
        launch(14'd0);
        check("zero_busy_after_start", 32'(busy), 32'd1);
        wait_done(lat, bcnt);
        check("zero_latency", 32'(lat), 32'd14);
        check("zero_busy_cycles", 32'(bcnt), 32'd14);
        check("zero_bcd", 32'(bcd), 32'h0000);
        check("zero_ovf", 32'(overflow), 32'd0);
        check("zero_busy_in_done", 32'(busy), 32'd0);
        tick();
        check("done_one_cycle", 32'(done), 32'd0);

        // Back-to-back: second start issued in the first done cycle
        launch(14'd255);
        wait_done(lat, bcnt);
        check("b2b_255_latency", 32'(lat), 32'd14);
        check("b2b_255_bcd", 32'(bcd), 32'h0255);
        check("b2b_255_ovf", 32'(overflow), 32'd0);
        launch(14'd9999);
        check("b2b_accept_busy", 32'(busy), 32'd1);
        wait_done(lat, bcnt);
        check("b2b_9999_latency", 32'(lat), 32'd14);
        check("b2b_9999_bcd", 32'(bcd), 32'h9999);
        check("b2b_9999_ovf", 32'(overflow), 32'd0);

        // Result holds after done
        for (int n = 0; n < 5; n++) tick();
        check("hold_bcd", 32'(bcd), 32'h9999);

        // Maximum input
        launch(14'd16383);
        wait_done(lat, bcnt);
`ifdef BIN2BCD_OVF_SAT_EN
        check("max_bcd", 32'(bcd), 32'h9999);
        check("max_ovf", 32'(overflow), 32'd1);
`else
        check("max_bcd", 32'(bcd), 32'h6383);
        check("max_ovf", 32'(overflow), 32'd0);
`endif
        tick();

        // Start while busy ignored, bin changes after acceptance ignored
        launch(14'd1234);
        dn      = 0;
        first_n = -1;
        bcd_at  = '0;
        for (int n = 1; n <= 24; n++) begin
            if (n == 3) bin = 14'd77;
            if (n == 5) begin
                start = 1'b1;
                bin   = 14'd42;
            end
            if (n == 6) start = 1'b0;
            tick();
            if (done) begin
                dn++;
                if (first_n < 0) begin
                    first_n = n;
                    bcd_at  = bcd;
                end
            end
        end
        check("busy_ign_done_count", 32'(dn), 32'd1);
        check("busy_ign_done_cycle", 32'(first_n), 32'd14);
        check("busy_ign_bcd", 32'(bcd_at), 32'h1234);

        // Reset mid-conversion aborts; start sampled with reset discarded
        launch(14'd5000);
        for (int n = 1; n <= 6; n++) tick();
        rst_n = 1'b0;
        start = 1'b1;
        bin   = 14'd321;
        tick();
        rst_n = 1'b0;
        start = 1'b0;
        check("abort_busy_in_reset", 32'(busy), 32'd0);
        rst_n = 1'b1;
        dn = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (done) dn++;
        end
        check("abort_no_done", 32'(dn), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd", 32'(bcd), 32'h0000);
        check("abort_ovf", 32'(overflow), 32'd0);
        launch(14'd10);
        wait_done(lat, bcnt);
        check("after_abort_latency", 32'(lat), 32'd14);
        check("after_abort_bcd", 32'(bcd), 32'h0010);

        // Random vectors against the decimal reference
        for (int i = 0; i < 1000; i++) begin
            rv = 14'($urandom_range(0, 16383));
            launch(rv);
            wait_done(lat, bcnt);
            exp_v = ref_model(int'(rv));
            check($sformatf("rand_bcd_%0d", rv), 32'(bcd), 32'(exp_v[15:0]));
            check($sformatf("rand_ovf_%0d", rv), 32'(overflow), 32'(exp_v[16]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
